reg_checker: RTL and testbench

REG_CHECKER -- requirements
Module: reg_checker

---
 rtl/reg_checker.sv | 143 ++++++++++++++
 tb/tb_reg_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_checker.sv
// reg_checker: shadow-model monitor for a simple load-enabled register.
//
// A WIDTH-bit model tracks every load of the observed register. Once
// armed and the first load has been seen, each clock edge compares the
// register's output with the model's value before that edge, and
// counts comparisons and mismatches. Both counters saturate at 0xFFFF.
// With HALT_ON_ERR != 0 the first mismatch parks the monitor in HALTED.
// Dropping enable returns it to IDLE and keeps all results; the next
// arm edge clears them.
//
// Optional feature: define REG_CHECKER_CAPTURE_EN to record the index
// and the expected/actual values of the first mismatch. Without the
// macro the first_err_* outputs are tied to zero and no capture
// registers exist.
module reg_checker #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned HALT_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             dut_load,
  input  logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic [1:0]       state_o,
  output logic             err_flag,
  output logic [15:0]      err_count,
  output logic [15:0]      check_count,
  output logic [15:0]      first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitLoad = 2'd1,
    StCheck    = 2'd2,
    StHalted   = 2'd3
  } state_e;

  localparam logic [15:0] CountMax = 16'hFFFF;

  state_e           state_q;
  logic [WIDTH-1:0] model_q;
  logic             err_flag_q;
  logic [15:0]      err_count_q;
  logic [15:0]      check_count_q;

  logic             arm;
  logic             do_cmp;
  logic             mismatch;
  logic [15:0]      err_count_inc;
  logic [15:0]      check_count_inc;

  // Decode this edge's events. Compares use the model value from before the edge.
  always_comb begin
    arm             = (state_q == StIdle) && enable;
    do_cmp          = (state_q == StCheck) && enable;
    mismatch        = do_cmp && (dut_out != model_q);
    err_count_inc   = (err_count_q == CountMax) ? err_count_q : err_count_q + 16'd1;
    check_count_inc = (check_count_q == CountMax) ? check_count_q : check_count_q + 16'd1;
  end

  // FSM, shadow model and result counters. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      model_q       <= '0;
      err_flag_q    <= 1'b0;
      err_count_q   <= '0;
      check_count_q <= '0;
    end else if (!enable) begin
      // Disarm from any state; results stay visible until the next arm edge.
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q       <= StWaitLoad;
          err_flag_q    <= 1'b0;
          err_count_q   <= '0;
          check_count_q <= '0;
        end
        StWaitLoad: begin
          if (dut_load) begin
            model_q <= dut_in;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          check_count_q <= check_count_inc;
          if (mismatch) begin
            err_count_q <= err_count_inc;
            err_flag_q  <= 1'b1;
            if (HALT_ON_ERR != 0) begin
              state_q <= StHalted;
            end
          end
          // The compare above used the old model; the load takes effect afterwards.
          if (dut_load) begin
            model_q <= dut_in;
          end
        end
        StHalted: begin
          // Everything frozen until enable drops or reset.
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign state_o     = state_q;
  assign err_flag    = err_flag_q;
  assign err_count   = err_count_q;
  assign check_count = check_count_q;

`ifdef REG_CHECKER_CAPTURE_EN
  logic [15:0]      first_idx_q;
  logic [WIDTH-1:0] first_exp_q;
  logic [WIDTH-1:0] first_act_q;

  // Record only the first mismatch since the last clear. A set err_flag marks it as taken.
  always_ff @(posedge clk) begin
    if (!rst_n || arm) begin
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
    end else if (mismatch && !err_flag_q) begin
      first_idx_q <= check_count_q;
      first_exp_q <= model_q;
      first_act_q <= dut_out;
    end
  end

  assign first_err_idx = first_idx_q;
  assign first_err_exp = first_exp_q;
  assign first_err_act = first_act_q;
`else
  assign first_err_idx = '0;
  assign first_err_exp = '0;
  assign first_err_act = '0;
`endif

endmodule

// File: tb/tb_reg_checker.sv
// tb_reg_checker: directed test of reg_checker. Two instances share the
// same stimulus: u_dut runs with HALT_ON_ERR=0 and u_halt with HALT_ON_ERR=1.
// All inputs are driven and all outputs sampled 1 time unit after the rising edge.
module tb_reg_checker;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          dut_load;
  logic [W-1:0]  dut_in;
  logic [W-1:0]  dut_out;

  logic [1:0]    a_state;
  logic          a_flag;
  logic [15:0]   a_err;
  logic [15:0]   a_chk;
  logic [15:0]   a_idx;
  logic [W-1:0]  a_exp;
  logic [W-1:0]  a_act;

  logic [1:0]    h_state;
  logic          h_flag;
  logic [15:0]   h_err;
  logic [15:0]   h_chk;
  logic [15:0]   h_idx;
  logic [W-1:0]  h_exp;
  logic [W-1:0]  h_act;

  int n_checks = 0;
  int n_fail   = 0;

  reg_checker #(.WIDTH(W), .HALT_ON_ERR(0)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .dut_load      (dut_load),
    .dut_in        (dut_in),
    .dut_out       (dut_out),
    .state_o       (a_state),
    .err_flag      (a_flag),
    .err_count     (a_err),
    .check_count   (a_chk),
    .first_err_idx (a_idx),
    .first_err_exp (a_exp),
    .first_err_act (a_act)
  );

  reg_checker #(.WIDTH(W), .HALT_ON_ERR(1)) u_halt (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .dut_load      (dut_load),
    .dut_in        (dut_in),
    .dut_out       (dut_out),
    .state_o       (h_state),
    .err_flag      (h_flag),
    .err_count     (h_err),
    .check_count   (h_chk),
    .first_err_idx (h_idx),
    .first_err_exp (h_exp),
    .first_err_act (h_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs stay as currently driven.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic en, input logic ld, input logic [W-1:0] din,
                       input logic [W-1:0] dout);
    enable   = en;
    dut_load = ld;
    dut_in   = din;
    dut_out  = dout;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 16'hFFFF, 16'h0000);

    // Reset for 2 cycles while enable and load are high.
    step(2);
    check_eq("rst_state", a_state, 2'd0);
    check_eq("rst_err", a_err, 16'd0);
    check_eq("rst_chk", a_chk, 16'd0);
    check_eq("rst_flag", a_flag, 1'b0);
    check_eq("rst_idx", a_idx, 16'd0);
    check_eq("rst_h_state", h_state, 2'd0);

    // Arm, load 0x00A5, then 10 matching compares.
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1);
    check_eq("arm_state", a_state, 2'd1);
    step(2);  // no load: stays in WAIT_LOAD without comparing
    check_eq("wait_state", a_state, 2'd1);
    check_eq("wait_chk", a_chk, 16'd0);
    drive(1'b1, 1'b1, 16'h00A5, 16'h0000);
    step(1);
    check_eq("load_state", a_state, 2'd2);
    check_eq("load_chk", a_chk, 16'd0);
    drive(1'b1, 1'b0, 16'h0000, 16'h00A5);
    step(10);
    check_eq("match_chk", a_chk, 16'd10);
    check_eq("match_err", a_err, 16'd0);
    check_eq("match_flag", a_flag, 1'b0);

    // Re-arm, load 0x1234, mismatch on the 3rd compare.
    drive(1'b0, 1'b0, 16'h0000, 16'h00A5);
    step(1);
    drive(1'b1, 1'b0, 16'h0000, 16'h00A5);
    step(1);
    check_eq("rearm_chk", a_chk, 16'd0);
    drive(1'b1, 1'b1, 16'h1234, 16'h0000);
    step(1);
    drive(1'b1, 1'b0, 16'h0000, 16'h1234);
    step(2);
    check_eq("pre_err", a_err, 16'd0);
    drive(1'b1, 1'b0, 16'h0000, 16'h1235);
    step(1);
    check_eq("mm_chk", a_chk, 16'd3);
    check_eq("mm_err", a_err, 16'd1);
    check_eq("mm_flag", a_flag, 1'b1);
`ifdef REG_CHECKER_CAPTURE_EN
    check_eq("cap_idx", a_idx, 16'd2);
    check_eq("cap_exp", a_exp, 16'h1234);
    check_eq("cap_act", a_act, 16'h1235);
`else
    check_eq("cap_idx_off", a_idx, 16'd0);
    check_eq("cap_exp_off", a_exp, 16'd0);
    check_eq("cap_act_off", a_act, 16'd0);
`endif

    // Load and compare on the same edge: compare uses the old model (0x1234).
    drive(1'b1, 1'b1, 16'h5555, 16'h1234);
    step(1);
    check_eq("same_edge_err", a_err, 16'd1);
    drive(1'b1, 1'b0, 16'h0000, 16'h5555);
    step(1);
    check_eq("new_model_err", a_err, 16'd1);
    check_eq("new_model_chk", a_chk, 16'd5);

    // Further mismatches must not move the capture.
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(3);
    check_eq("err_four", a_err, 16'd4);
`ifdef REG_CHECKER_CAPTURE_EN
    check_eq("cap_sticky_idx", a_idx, 16'd2);
    check_eq("cap_sticky_act", a_act, 16'h1235);
`else
    check_eq("cap_sticky_off", a_idx, 16'd0);
`endif

    // Drop enable with err_count=4: IDLE keeps results; re-arm clears them.
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1);
    check_eq("dis_state", a_state, 2'd0);
    check_eq("dis_err", a_err, 16'd4);
    step(2);
    check_eq("idle_err", a_err, 16'd4);
    check_eq("idle_flag", a_flag, 1'b1);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1);
    check_eq("rearm2_state", a_state, 2'd1);
    check_eq("rearm2_err", a_err, 16'd0);
    check_eq("rearm2_chk", a_chk, 16'd0);
    check_eq("rearm2_flag", a_flag, 1'b0);
    check_eq("rearm2_idx", a_idx, 16'd0);

    // HALT_ON_ERR: reset both, load 0x00FF, mismatch on the 1st compare.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1);
    drive(1'b1, 1'b1, 16'h00FF, 16'h0000);
    step(1);
    drive(1'b1, 1'b1, 16'hAAAA, 16'h0F0F);
    step(1);
    check_eq("halt_state", h_state, 2'd3);
    check_eq("halt_chk", h_chk, 16'd1);
    check_eq("halt_err", h_err, 16'd1);
    step(5);
    check_eq("halt_frz_state", h_state, 2'd3);
    check_eq("halt_frz_chk", h_chk, 16'd1);
    check_eq("halt_frz_err", h_err, 16'd1);
    // The non-halting instance kept comparing: 0x00FF, then 0xAAAA, both != 0x0F0F.
    check_eq("nohalt_chk", a_chk, 16'd6);
    check_eq("nohalt_err", a_err, 16'd6);

    // Reset mid-CHECK with a mismatch present: no partial update.
    rst_n = 1'b0;
    step(1);
    check_eq("midrst_state", a_state, 2'd0);
    check_eq("midrst_chk", a_chk, 16'd0);
    check_eq("midrst_err", a_err, 16'd0);
    check_eq("midrst_h_state", h_state, 2'd0);

    // Saturation: continuous mismatches well past 0xFFFF compares.
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(1);
    drive(1'b1, 1'b1, 16'h0001, 16'h0000);
    step(1);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000);
    step(65534);
    check_eq("sat_pre_chk", a_chk, 16'hFFFE);
    check_eq("sat_pre_err", a_err, 16'hFFFE);
    step(1);
    check_eq("sat_chk", a_chk, 16'hFFFF);
    step(4465);
    check_eq("sat_hold_chk", a_chk, 16'hFFFF);
    check_eq("sat_hold_err", a_err, 16'hFFFF);
    check_eq("sat_flag", a_flag, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
